seg_display_driver: RTL



---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg7_decode.sv | 13 +
 rtl/seg_display_driver.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display back end.
//   CODE_RIGHT/CODE_WRONG/CODE_BLANK : special display codes
//   SEG_PATTERN                      : active-low a..g pattern per 4-bit code (bit 0 = a)
package seg_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned SEG_W  = 7;

  localparam logic [CODE_W-1:0] CODE_RIGHT = 4'd10;
  localparam logic [CODE_W-1:0] CODE_WRONG = 4'd11;
  localparam logic [CODE_W-1:0] CODE_BLANK = 4'd15;

  // Entry i is the pattern for code i; 12..15 are blank.
  localparam logic [15:0][SEG_W-1:0] SEG_PATTERN = {
    7'h7F, 7'h7F, 7'h7F, 7'h7F,   // 15..12 blank
    7'h06,                        // 11 'E'
    7'h42,                        // 10 'G'
    7'h10, 7'h00, 7'h78, 7'h02,   // 9..6
    7'h12, 7'h19, 7'h30, 7'h24,   // 5..2
    7'h79, 7'h40                  // 1..0
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit display code to active-low segment pattern.
//   code      : display code
//   pattern_c : segments a..g, active-low, bit 0 = a
module seg7_decode
  import seg_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  pattern_c
);

  assign pattern_c = SEG_PATTERN[code];

endmodule

// File: rtl/seg_display_driver.sv
// 4-digit multiplexed common-anode display driver with a three-entry history
// of non-zero codes and optional blinking of result codes.
//   clk, reset : clock, asynchronous active-high reset
//   value      : display code from the game core, sampled every cycle
//   seg        : registered segments a..g, active-low
//   an         : registered digit enables, active-low, an[0] = rightmost
// Optional feature: define SEG_BLINK_EN to blink RIGHT/WRONG on digit 0.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50_000,
  parameter int unsigned GUARD       = 64,
  parameter int unsigned BLINK_DIV   = 12_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] value,
  output logic [SEG_W-1:0]  seg,
  output logic [3:0]        an
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if (GUARD >= REFRESH_DIV) begin : g_bad_guard
    $error("GUARD must be less than REFRESH_DIV");
  end
  if (BLINK_DIV == 0) begin : g_bad_blink
    $error("BLINK_DIV must be non-zero");
  end

  logic [CODE_W-1:0]        value_q;
  logic [2:0][CODE_W-1:0]   hist;
  logic [REF_W-1:0]         refresh_cnt;
  logic [1:0]               digit_idx;
  logic                     change;
  logic                     ref_wrap;
  logic                     in_guard;
  logic                     blink_off;
  logic [CODE_W-1:0]        digit_code;
  logic [SEG_W-1:0]         pattern_c;

  assign change   = (value != value_q);
  assign ref_wrap = (refresh_cnt == REF_W'(REFRESH_DIV - 1));
  assign in_guard = (refresh_cnt < REF_W'(GUARD));

  // Input capture and history shift; a change away from 0 never pushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      hist    <= {CODE_BLANK, CODE_BLANK, CODE_BLANK};
    end else begin
      value_q <= value;
      if (change && (value_q != '0)) begin
        hist <= {hist[1], hist[0], value_q};
      end
    end
  end

  // Digit scan timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (ref_wrap) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  // Blink timebase; an input change restarts the on-phase and beats a wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (change) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLK_W'(1);
    end
  end

  assign blink_off = blink_phase &&
                     ((value_q == CODE_RIGHT) || (value_q == CODE_WRONG));
`else
  assign blink_off = 1'b0;
`endif

  // Code of the digit currently being scanned.
  always_comb begin
    digit_code = CODE_BLANK;
    case (digit_idx)
      2'd0:    digit_code = blink_off ? CODE_BLANK : value_q;
      2'd1:    digit_code = hist[0];
      2'd2:    digit_code = hist[1];
      default: digit_code = hist[2];
    endcase
  end

  seg7_decode u_decode (
    .code      (digit_code),
    .pattern_c (pattern_c)
  );

  // seg and an load from the same scan state, so they always match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= '1;
      an  <= 4'hF;
    end else begin
      seg <= pattern_c;
      an  <= in_guard ? 4'hF : ~(4'b0001 << digit_idx);
    end
  end

endmodule
